jtdsp16_sdo_rx: RTL

Serial-output receiver that sits directly downstream of the DSP16 core's serial port. It samples `sdo` on rising edges of `ock` and frames 16-bit words with `old`. Words alternate left/right, and each completed stereo pair is pushed into a small FIFO. The FIFO is drained by the audio mixer through a valid/ready handshake.

---
 rtl/jtdsp16_sdo_rx_pkg.sv | 20 ++
 rtl/jtdsp16_sdo_fifo.sv | 71 +++++++
 rtl/jtdsp16_sdo_rx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/jtdsp16_sdo_rx_pkg.sv
// Shared types and helpers for the DSP16 serial-output receiver.
// Purely combinational content, no latency.
// No flow control here; users apply their own handshake.
package jtdsp16_sdo_rx_pkg;

   localparam int SDO_W = 16;

   typedef struct packed {
      logic [SDO_W-1:0] left;
      logic [SDO_W-1:0] right;
   } sdo_pair_t;

   // Insert one serial bit so that after SDO_W bits the word reads as transmitted.
   function automatic logic [SDO_W-1:0] shift_in(input logic [SDO_W-1:0] w,
                                                  input logic             b,
                                                  input logic             msb_first);
      return msb_first ? {w[SDO_W-2:0], b} : {b, w[SDO_W-1:1]};
   endfunction

endpackage

// File: rtl/jtdsp16_sdo_fifo.sv
// Synchronous FIFO with registered head outputs, depth 2^AW.
// Write to readable head: 1 cycle (no fall-through).
// Push when full without a same-cycle pop is dropped and reported on drop.
module jtdsp16_sdo_fifo #(
   parameter int DW = 32,
   parameter int AW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          ready,
   output logic          valid,
   output logic          full,
   output logic          drop,
   output logic [DW-1:0] head
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_nxt;
   logic [AW:0]   count;
   logic          pop;
   logic          wr;
   logic          one_left;

   assign valid    = (count != '0);
   assign full     = count[AW];
   assign pop      = valid & ready;
   assign wr       = push & (~full | pop);
   assign drop     = push & full & ~pop;
   assign rd_nxt   = rd_ptr + 1'b1;
   assign one_left = (count == (AW+1)'(1));

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr)  wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_nxt;
         case ({wr, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head register: the incoming pair becomes head when the FIFO is (or is becoming) empty,
   // otherwise a pop advances to the next stored entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
      end else if (wr && (!valid || (one_left && pop))) begin
         head <= din;
      end else if (pop && !one_left) begin
         head <= mem[rd_nxt];
      end
   end

endmodule

// File: rtl/jtdsp16_sdo_rx.sv
// DSP16 serial-output receiver: frames 16-bit words on ock/old and queues stereo pairs.
// Last bit of a right word to out_valid: 2 clk cycles when the FIFO was empty.
// Holds the head pair while out_ready is low; pairs arriving on a full FIFO are dropped (overrun).
module jtdsp16_sdo_rx
   import jtdsp16_sdo_rx_pkg::*;
#(
   parameter int MSB_FIRST = 0,
   parameter int AW        = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sdo,
   input  logic        ock,
   input  logic        old,
   output logic [15:0] out_left,
   output logic [15:0] out_right,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        clr_flags,
   output logic        overrun,
   output logic        sync_err
);
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   localparam logic MSB = (MSB_FIRST != 0);

   state_t           state;
   logic             ock_l;
   logic             bit_en;
   logic [4:0]       bitcnt;
   logic [SDO_W-1:0] sreg;
   logic [SDO_W-1:0] lhold;
   logic             word_done;
   logic             ch;
   logic             push;
   logic             drop;
   logic             fifo_full;
   logic             sync_ev;
   sdo_pair_t        pair_in;
   sdo_pair_t        pair_head;

   assign bit_en  = ock & ~ock_l;
   assign sync_ev = bit_en & old & (state == SHIFT);

   // Delayed copy of ock for rising-edge detection.
   always_ff @(posedge clk) begin
      ock_l <= ock;
   end

   // Word framing FSM and shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         bitcnt    <= '0;
         sreg      <= '0;
         word_done <= 1'b0;
      end else begin
         word_done <= 1'b0;
         if (bit_en) begin
            case (state)
               IDLE: begin
                  if (old) begin
                     sreg   <= shift_in(sreg, sdo, MSB);
                     bitcnt <= 5'd1;
                     state  <= SHIFT;
                  end
               end
               SHIFT: begin
                  sreg <= shift_in(sreg, sdo, MSB);
                  if (old) begin
                     bitcnt <= 5'd1;
                  end else if (bitcnt == 5'd15) begin
                     bitcnt    <= '0;
                     state     <= IDLE;
                     word_done <= 1'b1;
                  end else begin
                     bitcnt <= bitcnt + 5'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Left/right steering: a left word is parked, a right word completes the pair.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch    <= 1'b0;
         lhold <= '0;
      end else if (word_done) begin
         if (!ch) lhold <= sreg;
         ch <= ~ch;
      end
   end

   assign push          = word_done & ch;
   assign pair_in.left  = lhold;
   assign pair_in.right = sreg;

   jtdsp16_sdo_fifo #(
      .DW (2*SDO_W),
      .AW (AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (pair_in),
      .ready (out_ready),
      .valid (out_valid),
      .full  (fifo_full),
      .drop  (drop),
      .head  (pair_head)
   );

   assign out_left  = pair_head.left;
   assign out_right = pair_head.right;

   // Sticky status flags; a new event in the clear cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun  <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         if (drop)           overrun <= 1'b1;
         else if (clr_flags) overrun <= 1'b0;
         if (sync_ev)        sync_err <= 1'b1;
         else if (clr_flags) sync_err <= 1'b0;
      end
   end

endmodule
